// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared constants, op encodings and FSM state type for the vector logical unit
package valu_pkg;

  localparam int VALU_DATA_WIDTH  = 64;
  localparam int VALU_ADDR_WIDTH  = 32;
  localparam int VALU_OPSEL_WIDTH = 2;
  localparam int VALU_LEN_WIDTH   = 8;

  localparam logic [1:0] VALU_OP_ZERO = 2'b00;
  localparam logic [1:0] VALU_OP_AND  = 2'b01;
  localparam logic [1:0] VALU_OP_OR   = 2'b10;
  localparam logic [1:0] VALU_OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    VALU_IDLE  = 2'd0,
    VALU_READ  = 2'd1,
    VALU_DRAIN = 2'd2,
    VALU_DONE  = 2'd3
  } valu_state_e;

endpackage

// File: rtl/valu_beat_counter.sv
// rtl/valu_beat_counter.sv - clearable beat counter that saturates at len and flags the last beat
module valu_beat_counter #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [LEN_WIDTH-1:0] len,
  output logic [LEN_WIDTH-1:0] count,
  output logic                 at_last
);

  logic at_len;

  assign at_len  = (count == len);
  assign at_last = (count == len - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !at_len) begin
      count <= count + LEN_WIDTH'(1);
    end
  end

endmodule

// File: rtl/valu_issue_seq.sv
// rtl/valu_issue_seq.sv - vector logical unit command sequencer: VRF reads, ALU issue, response count
// Optional feature macro: VALU_ISSUE_STALL_EN (adds issue_stall input to pause reads in READ).
module valu_issue_seq
  import valu_pkg::*;
#(
  parameter int DATA_WIDTH  = VALU_DATA_WIDTH,
  parameter int ADDR_WIDTH  = VALU_ADDR_WIDTH,
  parameter int OPSEL_WIDTH = VALU_OPSEL_WIDTH,
  parameter int LEN_WIDTH   = VALU_LEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPSEL_WIDTH-1:0] cmd_opsel,
  input  logic [ADDR_WIDTH-1:0]  cmd_vs1,
  input  logic [ADDR_WIDTH-1:0]  cmd_vs2,
  input  logic [ADDR_WIDTH-1:0]  cmd_vd,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
`ifdef VALU_ISSUE_STALL_EN
  input  logic                   issue_stall,
`endif
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr0,
  output logic [ADDR_WIDTH-1:0]  rd_addr1,
  input  logic [DATA_WIDTH-1:0]  rd_data0,
  input  logic [DATA_WIDTH-1:0]  rd_data1,
  output logic                   alu_valid,
  output logic [OPSEL_WIDTH-1:0] alu_opsel,
  output logic [DATA_WIDTH-1:0]  alu_vec0,
  output logic [DATA_WIDTH-1:0]  alu_vec1,
  output logic [ADDR_WIDTH-1:0]  alu_addr,
  input  logic                   alu_resp_valid,
  output logic                   busy,
  output logic                   done
);

  valu_state_e state_q, state_d;

  logic [OPSEL_WIDTH-1:0] op_q;
  logic [ADDR_WIDTH-1:0]  vs1_q, vs2_q, vd_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat, resp_count;
  logic [ADDR_WIDTH-1:0]  beat_ext;
  logic                   beat_at_last, resp_at_last;
  logic                   accept, stall, rd_fire, resp_done;

`ifdef VALU_ISSUE_STALL_EN
  assign stall = issue_stall;
`else
  assign stall = 1'b0;
`endif

  assign accept   = cmd_valid && (state_q == VALU_IDLE);
  assign rd_fire  = (state_q == VALU_READ) && !stall;
  assign beat_ext = ADDR_WIDTH'(beat);

  // Counts the response arriving this cycle so DONE follows the last response without a bubble.
  assign resp_done = (resp_count == len_q) || (resp_at_last && alu_resp_valid);

  valu_beat_counter #(.LEN_WIDTH(LEN_WIDTH)) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .inc     (rd_fire),
    .len     (len_q),
    .count   (beat),
    .at_last (beat_at_last)
  );

  valu_beat_counter #(.LEN_WIDTH(LEN_WIDTH)) u_resp_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .inc     (alu_resp_valid && busy),
    .len     (len_q),
    .count   (resp_count),
    .at_last (resp_at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VALU_IDLE;
      op_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_opsel;
        vs1_q <= cmd_vs1;
        vs2_q <= cmd_vs2;
        vd_q  <= cmd_vd;
        len_q <= cmd_len;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VALU_IDLE:  if (accept) state_d = (cmd_len != '0) ? VALU_READ : VALU_DONE;
      VALU_READ:  if (rd_fire && beat_at_last) state_d = VALU_DRAIN;
      VALU_DRAIN: if (resp_done && !alu_valid) state_d = VALU_DONE;
      VALU_DONE:  state_d = VALU_IDLE;
      default:    state_d = VALU_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == VALU_IDLE);
    busy      = (state_q != VALU_IDLE);
    done      = (state_q == VALU_DONE);
    rd_en     = rd_fire;
    rd_addr0  = rd_fire ? vs1_q + beat_ext : '0;
    rd_addr1  = rd_fire ? vs2_q + beat_ext : '0;
  end

  // Issue stage: read data lands the cycle after rd_en, so it passes straight through under alu_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_opsel <= '0;
      alu_addr  <= '0;
    end else begin
      alu_valid <= rd_fire;
      alu_opsel <= rd_fire ? op_q : '0;
      alu_addr  <= rd_fire ? vd_q + beat_ext : '0;
    end
  end

  assign alu_vec0 = alu_valid ? rd_data0 : '0;
  assign alu_vec1 = alu_valid ? rd_data1 : '0;

endmodule

// File: tb/tb_valu_issue_seq.sv
// tb/tb_valu_issue_seq.sv - directed table-driven bench for valu_issue_seq with VRF and 6-cycle ALU models
module tb_valu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_opsel;
  logic [31:0] cmd_vs1, cmd_vs2, cmd_vd;
  logic [7:0]  cmd_len;
  logic        issue_stall;
  logic        rd_en;
  logic [31:0] rd_addr0, rd_addr1;
  logic [63:0] rd_data0, rd_data1;
  logic        alu_valid;
  logic [1:0]  alu_opsel;
  logic [63:0] alu_vec0, alu_vec1;
  logic [31:0] alu_addr;
  logic        alu_resp_valid;
  logic        busy, done;
  logic [5:0]  pipe = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  valu_issue_seq dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opsel      (cmd_opsel),
    .cmd_vs1        (cmd_vs1),
    .cmd_vs2        (cmd_vs2),
    .cmd_vd         (cmd_vd),
    .cmd_len        (cmd_len),
`ifdef VALU_ISSUE_STALL_EN
    .issue_stall    (issue_stall),
`endif
    .rd_en          (rd_en),
    .rd_addr0       (rd_addr0),
    .rd_addr1       (rd_addr1),
    .rd_data0       (rd_data0),
    .rd_data1       (rd_data1),
    .alu_valid      (alu_valid),
    .alu_opsel      (alu_opsel),
    .alu_vec0       (alu_vec0),
    .alu_vec1       (alu_vec1),
    .alu_addr       (alu_addr),
    .alu_resp_valid (alu_resp_valid),
    .busy           (busy),
    .done           (done)
  );

  // VRF returns an address-tagged word one cycle after rd_en; the ALU answers 6 cycles after alu_valid.
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[4:0], alu_valid};
    rd_data0 <= rd_en ? {32'hA0A0A0A0, rd_addr0} : 64'hDEADBEEFDEADBEEF;
    rd_data1 <= rd_en ? {32'hB0B0B0B0, rd_addr1} : 64'hFEEDFACEFEEDFACE;
  end
  assign alu_resp_valid = pipe[5];

  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic [31:0] vs1, vs2, vd;
    logic [7:0]  len;
    logic        rdy, rd;
    logic [31:0] ra0, ra1;
    logic        av;
    logic [31:0] aa, v0, v1;
    logic [1:0]  aop;
    logic        bsy, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cv, logic [1:0] op, logic [31:0] vs1, logic [31:0] vs2,
                              logic [31:0] vd, logic [7:0] len, logic rdy, logic rd,
                              logic [31:0] ra0, logic [31:0] ra1, logic av, logic [31:0] aa,
                              logic [31:0] v0, logic [31:0] v1, logic [1:0] aop, logic bsy, logic dn);
    vec_t v;
    v.cv = cv; v.op = op; v.vs1 = vs1; v.vs2 = vs2; v.vd = vd; v.len = len;
    v.rdy = rdy; v.rd = rd; v.ra0 = ra0; v.ra1 = ra1; v.av = av; v.aa = aa;
    v.v0 = v0; v.v1 = v1; v.aop = aop; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [31:0] vs1, input logic [31:0] vs2,
                       input logic [31:0] vd, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_opsel = op; cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vd = vd; cmd_len = len;
  endtask

  logic [31:0] rd_m, av_m, dn_m;
  logic [63:0] exp_v0, exp_v1;
  int          dn_cnt;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opsel = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vd = '0;
    cmd_len = '0; issue_stall = 1'b0;

    // A: and, len 4
    tbl.push_back(mk(1, 1, 32'h10, 32'h20, 32'h30, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h20, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 32'h21, 1, 32'h30, 32'h10, 32'h20, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h12, 32'h22, 1, 32'h31, 32'h11, 32'h21, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 32'h23, 1, 32'h32, 32'h12, 32'h22, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33, 32'h13, 32'h23, 1, 1, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // B: len 0 accepted the cycle after done
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // C: xor, len 3, address wrap-around
    tbl.push_back(mk(1, 3, 32'hFFFFFFFE, 32'h100, 32'hFFFFFFFF, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 32'h100, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'h101, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h100, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h00000000, 32'h102, 1, 32'h00000000, 32'hFFFFFFFF, 32'h101, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000001, 32'h00000000, 32'h102, 3, 1, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset outputs", {rd_en, alu_valid, busy, done, alu_opsel}, 64'd0);
    chk("reset addrs", {rd_addr0, rd_addr1} | 64'(alu_addr), 64'd0);
    chk("reset vecs", alu_vec0 | alu_vec1, 64'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].cv; cmd_opsel = tbl[i].op; cmd_vs1 = tbl[i].vs1;
      cmd_vs2 = tbl[i].vs2; cmd_vd = tbl[i].vd; cmd_len = tbl[i].len;
      exp_v0 = tbl[i].av ? {32'hA0A0A0A0, tbl[i].v0} : 64'd0;
      exp_v1 = tbl[i].av ? {32'hB0B0B0B0, tbl[i].v1} : 64'd0;
      @(negedge clk);
      chk($sformatf("row%0d cmd_ready", i), 64'(cmd_ready), 64'(tbl[i].rdy));
      chk($sformatf("row%0d rd_en", i), 64'(rd_en), 64'(tbl[i].rd));
      chk($sformatf("row%0d rd_addr", i), {rd_addr0, rd_addr1}, {tbl[i].ra0, tbl[i].ra1});
      chk($sformatf("row%0d alu_valid", i), 64'(alu_valid), 64'(tbl[i].av));
      chk($sformatf("row%0d alu_addr", i), 64'(alu_addr), 64'(tbl[i].aa));
      chk($sformatf("row%0d alu_opsel", i), 64'(alu_opsel), 64'(tbl[i].aop));
      chk($sformatf("row%0d alu_vec0", i), alu_vec0, exp_v0);
      chk($sformatf("row%0d alu_vec1", i), alu_vec1, exp_v1);
      chk($sformatf("row%0d busy/done", i), {busy, done}, {tbl[i].bsy, tbl[i].dn});
      next_cycle();
    end

    // cmd_valid held through a len=2 command: the second one waits for the cycle after done
    offer(1, 32'h40, 32'h50, 32'h60, 2);
    rd_m = '0; av_m = '0; dn_m = '0;
    for (int c = 0; c < 23; c++) begin
      if (c == 12) cmd_valid = 1'b0;
      @(negedge clk);
      rd_m[c] = rd_en; av_m[c] = alu_valid; dn_m[c] = done;
      next_cycle();
    end
    chk("held rd_en pattern", 64'(rd_m), 64'h3006);
    chk("held alu_valid pattern", 64'(av_m), 64'h600C);
    chk("held done pattern", 64'(dn_m), 64'h200400);

    // reset in the middle of a len=8 command
    offer(2, 32'h200, 32'h300, 32'h400, 8);
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("abort cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort outputs", {rd_en, alu_valid, busy, done, alu_opsel}, 64'd0);
    chk("abort addrs", {rd_addr0, rd_addr1} | 64'(alu_addr), 64'd0);
    dn_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      @(negedge clk);
      dn_cnt += int'(done) + int'(busy);
    end
    chk("abort no done/busy", 64'(dn_cnt), 64'd0);
    next_cycle();
    offer(1, 32'h500, 32'h600, 32'h700, 1);
    dn_m = '0; av_m = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) cmd_valid = 1'b0;
      @(negedge clk);
      av_m[c] = alu_valid; dn_m[c] = done;
      next_cycle();
    end
    chk("post-abort alu_valid", 64'(av_m), 64'h4);
    chk("post-abort done", 64'(dn_m), 64'h200);

`ifdef VALU_ISSUE_STALL_EN
    offer(1, 32'h10, 32'h20, 32'h30, 4);
    rd_m = '0; dn_m = '0;
    for (int c = 0; c < 16; c++) begin
      if (c == 1) cmd_valid = 1'b0;
      issue_stall = (c == 2 || c == 3);
      @(negedge clk);
      rd_m[c] = rd_en; dn_m[c] = done;
      next_cycle();
    end
    issue_stall = 1'b0;
    chk("stall rd_en pattern", 64'(rd_m), 64'h72);
    chk("stall done", 64'(dn_m), 64'h4000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/valu_issue_seq.md
# valu_issue_seq

Command-side sequencer for the pipelined vector logical unit (AND/OR/XOR). It accepts one vector command at a time from dispatch and reads both source operands from the vector register file, one beat per cycle. It then drives the ALU request port (valid/opsel/vec0/vec1/addr) and counts the ALU's returning valid pulses, signalling completion once every beat has been written back.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result beat width
- ADDR_WIDTH, 32, register-file word address width
- OPSEL_WIDTH, 2, ALU op select (01 and, 10 or, 11 xor, 00 zero)
- LEN_WIDTH, 8, beat count width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command accepted when both high
- cmd_opsel  in  OPSEL_WIDTH  operation
- cmd_vs1, cmd_vs2, cmd_vd  in  ADDR_WIDTH  base word addresses
- cmd_len  in  LEN_WIDTH  beats (0 = no-op)
- rd_en  out  1  VRF read strobe
- rd_addr0, rd_addr1  out  ADDR_WIDTH  read addresses
- rd_data0, rd_data1  in  DATA_WIDTH  read data, valid cycle after rd_en
- alu_valid  out  1  ALU request valid
- alu_opsel  out  OPSEL_WIDTH  op select to ALU
- alu_vec0, alu_vec1  out  DATA_WIDTH  operands
- alu_addr  out  ADDR_WIDTH  destination address for this beat
- alu_resp_valid  in  1  ALU result-valid pulse
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, DRAIN, DONE. cmd_ready = (state==IDLE).
- IDLE: on accept, latch opsel/bases/len and clear beat and response counters. Next state is READ if len!=0, otherwise DONE.
- READ: each cycle rd_en=1, rd_addr0=vs1+beat, rd_addr1=vs2+beat, beat++. Go to DRAIN on the cycle after the read with beat==len-1.
- Issue stage (registered, one cycle behind rd_en):
  - alu_valid = rd_en delayed 1.
  - alu_vec0/1 = rd_data0/1 when valid, zero otherwise.
  - alu_opsel = latched op when valid, zero otherwise.
  - alu_addr = vd+beat delayed 1 when valid, zero otherwise.
- Response counter increments on alu_resp_valid while busy and saturates at len. alu_resp_valid in IDLE is ignored.
- DRAIN: wait until the response count equals len and the issue stage is empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = (state!=IDLE).
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is legal and silent.
- Reset mid-operation aborts the command: state IDLE, all counters clear, no done pulse.

## Timing
- Reset values: cmd_ready=1 (first cycle after reset). All other outputs are 0: rd_en, rd_addr0/1, alu_valid, alu_opsel, alu_vec0/1, alu_addr, busy, done.
- Accept at cycle T:
  - rd_en high T+1..T+len.
  - alu_valid high T+2..T+len+1, back-to-back.
- With the 6-cycle ALU, responses arrive T+8..T+len+7 and done is high at T+len+8.
- len=0: done at T+1, no reads, no ALU traffic.
- Next command can be accepted the cycle after done (cmd_ready high again).
- A cmd_valid held during busy is not accepted; the command must remain stable until accepted.

## Configuration
- VALU_ISSUE_STALL_EN defined:
  - Adds input issue_stall (1 bit).
  - While it is high in READ, rd_en=0 and beat is held; the issue stage drains normally.
  - Stalling in IDLE/DRAIN has no effect.
- Undefined: no port, and reads issue every cycle in READ.

## Structure
- Shared package valu_pkg holds:
  - opsel constants: VALU_OP_ZERO, VALU_OP_AND, VALU_OP_OR, VALU_OP_XOR.
  - state encoding: IDLE/READ/DRAIN/DONE.
  - default width constants.
- Sub-module valu_beat_counter (load/increment/compare-to-len, LEN_WIDTH) is instantiated twice: once for beats issued, once for responses.

## Test plan
- vs1=0x10, vs2=0x20, vd=0x30, len=4, opsel=01, VRF returns A_i/B_i -> rd_addr 0x10..0x13/0x20..0x23 on T+1..T+4; alu_addr 0x30..0x33 with alu_vec0=A_i, alu_vec1=B_i on T+2..T+5; done at T+12.
- len=0 -> done at T+1; rd_en and alu_valid never assert; cmd_ready back at T+2.
- vs1=0xFFFFFFFE, len=3 -> rd_addr0 = 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- cmd_valid held high through a len=2 command -> second command accepted only the cycle after done; no overlap of alu_valid between commands.
- rst asserted at T+3 of a len=8 command -> all outputs 0 next cycle; done never pulses; new command accepted normally afterwards.
- With VALU_ISSUE_STALL_EN: len=4, issue_stall high T+2..T+3 -> rd_en on T+1, T+4, T+5, T+6; done at T+14.
